imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
- Boot/load controller for the 32-word instruction memory.
- Receives a byte stream from an external programming link (UART receiver or debug port) over a valid/ready handshake.
- Assembles the bytes into 32-bit little-endian words and writes them sequentially from word 0.
- Holds the core in reset until loading completes, then hands the memory read port to the core's fetch address (PC).

Parameters:
- DEPTH, 32, number of instruction words; must be a power of two.
- ADDR_W, 5, word-index width, equal to log2(DEPTH).
- NOP_INSTR, 32'h00000013, value driven on core_instr while the core does not own the memory (encodes addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- byte_valid  input  1  a stream byte is present on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  controller accepts a byte; a byte is taken when byte_valid && byte_ready at a rising edge.
- reload  input  1  single-cycle pulse requesting a fresh load.
- core_pc  input  32  core fetch address, byte-addressed.
- core_instr  output  32  instruction returned to the core.
- cpu_rst_n  output  1  active-low reset to the core.
- mem_we  output  1  write enable to the instruction RAM.
- mem_addr  output  ADDR_W  word index to the RAM.
- mem_wdata  output  32  write data to the RAM.
- mem_rdata  input  32  RAM asynchronous read data.
- load_done  output  1  high while in DONE.
- load_err  output  1  high while in ERR.

Behaviour:
- Reset values: state=IDLE, cpu_rst_n=0, mem_we=0, mem_wdata=0, word_cnt=0, byte_idx=0, count=0, load_done=0, load_err=0.
- byte_ready is combinational: 1 in IDLE and LOAD, 0 in DONE and ERR. It is therefore 1 in the first cycle after reset.
- IDLE, count byte: the first accepted byte is the word count N.
  - N==0 -> DONE.
  - N>DEPTH -> ERR.
  - Otherwise store N -> LOAD.
- LOAD, byte assembly: accepted bytes fill a 32-bit shift register, least-significant byte first. byte_idx counts 0..3.
  - On the 4th byte, the next cycle has mem_we=1 (one cycle), mem_addr=word_cnt, and mem_wdata=the assembled word. word_cnt then increments.
  - A byte accepted in the same cycle that mem_we is high is legal and starts the next word. There is no stall.
- LOAD completion: after the write of word N-1, the next state is DONE. Words at index >= N keep their previous contents.
- DONE:
  - cpu_rst_n=1 starting the first cycle in DONE.
  - mem_we=0.
  - mem_addr=core_pc[ADDR_W+1:2]. core_pc[1:0] and the bits above ADDR_W+1 are ignored, so the address wraps modulo DEPTH.
  - core_instr=mem_rdata, combinational with zero latency.
- Memory port outside DONE:
  - In IDLE, LOAD and ERR, mem_addr=word_cnt.
  - core_instr=NOP_INSTR.
  - cpu_rst_n=0.
- ERR: sticky. byte_ready=0 and bytes are ignored. Only reload or rst_n leaves ERR.
- reload:
  - From any state -> IDLE on the next edge: word_cnt=0, byte_idx=0, cpu_rst_n=0 from that edge onward.
  - In LOAD, a partially assembled word is discarded and words already written are kept.
  - A reload in the same cycle as a byte handshake wins; that byte is dropped.
  - A reload in the same cycle as the final write still performs that write, then goes to IDLE.
- rst_n low mid-load: everything returns to reset values immediately and asynchronously. An in-flight mem_we is cancelled.
- Arithmetic: word_cnt is ADDR_W+1 bits wide so it can hold DEPTH. Comparisons against N use that width. count is 8 bits.

Decomposition:
- Shared package (riscv_pkg):
  - State encoding IDLE=2'd0, LOAD=2'd1, DONE=2'd2, ERR=2'd3.
  - Constant NOP_INSTR.
  - Constant IMEM_DEPTH=32.
- Sub-module byte_packer: shift register plus byte_idx counter. It outputs word_valid (1-cycle) and word[31:0], and has a clear input.
- The FSM, address mux and reset gating stay in the top level.

Test Plan:
- Basic load: reset, then stream 02, 13 05 10 00, B3 00 21 00 -> mem_we pulses at addr 0 with data 32'h00100513 and at addr 1 with data 32'h002100B3. cpu_rst_n rises the cycle after the 2nd write. With core_pc=32'h4 and mem_rdata echoing the RAM, core_instr=32'h002100B3.
- Zero count: stream 00 -> DONE next cycle, no mem_we, cpu_rst_n=1, byte_ready=0.
- Overflow: stream 21 (33) -> load_err=1, cpu_rst_n stays 0, further bytes not accepted, core_instr=32'h00000013. Then a reload pulse -> IDLE, load_err=0.
- Back-to-back: byte_valid held high continuously for a full 32-word load (count 20 followed by 128 bytes) -> exactly 32 mem_we pulses at addr 0..31, with no dropped byte, including bytes accepted during mem_we cycles.
- Mid-load abort: after 6 bytes of a 3-word load, pulse reload -> word 0 was written, the partial word is not written, and the state is IDLE. Reloading 01, EF BE AD DE then writes addr 0 with data 32'hDEADBEEF.
- Async reset: assert rst_n low in the cycle mem_we=1 during LOAD -> mem_we and cpu_rst_n go to 0 without waiting for a clock edge. After release, byte_ready=1 and the next byte is taken as the count.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package riscv_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2,
    StErr  = 2'd3
  } boot_state_e;

  localparam int unsigned ImemDepth = 32;
  // addi x0, x0, 0
  localparam logic [31:0] NopInstr  = 32'h0000_0013;

endpackage

// File: rtl/imem_boot_ctrl_byte_packer.sv
// Assembles a byte stream into 32-bit little-endian words, least-significant byte first.
module imem_boot_ctrl_byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    if (clear_i) begin
      byte_idx_d = 2'd0;
      shift_d    = 24'd0;
    end else if (byte_valid_i) begin
      byte_idx_d = byte_idx_q + 2'd1;
      shift_d    = {byte_i, shift_q[23:8]};
    end
  end

  // The fourth byte completes the word directly from the input, without a shift.
  assign word_valid_o = byte_valid_i && !clear_i && (byte_idx_q == 2'd3);
  assign word_o       = {byte_i, shift_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_idx_q <= 2'd0;
      shift_q    <= 24'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader: streams a program into instruction RAM, then releases the core and
// hands the RAM read port to the core's fetch address.
module imem_boot_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned Depth     = ImemDepth,
  parameter int unsigned AddrW     = $clog2(Depth),
  parameter logic [31:0] IdleInstr = NopInstr
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  input  logic             reload_i,
  input  logic [31:0]      core_pc_i,
  output logic [31:0]      core_instr_o,
  output logic             cpu_rst_no,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  output logic             load_done_o,
  output logic             load_err_o
);

  localparam int unsigned CntW = AddrW + 1;

  boot_state_e     state_q, state_d;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;
  logic [CntW-1:0] word_cnt_inc;
  logic [7:0]      count_q, count_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  logic            take;
  logic            pack_clear;
  logic            word_valid;
  logic [31:0]     word;
  logic            unused_pc;

  assign byte_ready_o = (state_q == StIdle) || (state_q == StLoad);
  // A reload in the same cycle as a handshake drops that byte.
  assign take         = byte_valid_i && byte_ready_o && !reload_i;
  assign pack_clear   = reload_i || (state_q != StLoad);
  assign word_cnt_inc = word_cnt_q + 1'b1;

  imem_boot_ctrl_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (pack_clear),
    .byte_valid_i (take && (state_q == StLoad)),
    .byte_i       (byte_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (take) begin
          if (byte_data_i == 8'd0) begin
            state_d = StDone;
          end else if (byte_data_i > 8'(Depth)) begin
            state_d = StErr;
          end else begin
            count_d = byte_data_i;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = word;
        end
        // The address advances only once the write cycle has been presented.
        if (mem_we_q) begin
          word_cnt_d = word_cnt_inc;
          if (8'(word_cnt_inc) == count_q) begin
            state_d = StDone;
          end
        end
      end
      StDone, StErr: ;
      default: state_d = StIdle;
    endcase

    if (reload_i) begin
      state_d    = StIdle;
      word_cnt_d = '0;
      mem_we_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      count_q     <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we_o     = mem_we_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign cpu_rst_no   = (state_q == StDone);
  assign load_done_o  = (state_q == StDone);
  assign load_err_o   = (state_q == StErr);
  assign mem_addr_o   = (state_q == StDone) ? core_pc_i[AddrW+1:2] : word_cnt_q[AddrW-1:0];
  assign core_instr_o = (state_q == StDone) ? mem_rdata_i : IdleInstr;

  // Byte offset and out-of-range PC bits wrap the fetch address.
  assign unused_pc = ^{core_pc_i[31:AddrW+2], core_pc_i[1:0]};

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: expected RAM writes are queued by the stimulus and
// popped by an independent write monitor; fetches are checked against a model memory.
module tb_imem_boot_ctrl;

  localparam int Depth = 32;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        reload = 1'b0;
  logic [31:0] core_pc = 32'd0;
  logic [31:0] core_instr;
  logic        cpu_rst_n;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        load_done;
  logic        load_err;

  logic [31:0] ram   [Depth];
  logic [31:0] model [Depth];
  logic [36:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  imem_boot_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .reload_i     (reload),
    .core_pc_i    (core_pc),
    .core_instr_o (core_instr),
    .cpu_rst_no   (cpu_rst_n),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .load_done_o  (load_done),
    .load_err_o   (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every mem_we cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                 mem_addr, mem_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[36:32]));
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Drives a byte from a negedge and returns on the negedge after it is taken.
  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = byte_ready;
      @(posedge clk);
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got byte_ready=0 expected a handshake");
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      send(b);
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic expect_word(input int addr, input logic [31:0] w);
    exp_q.push_back({5'(addr), w});
    model[addr] = w;
  endtask

  task automatic pulse_reload();
    byte_valid = 1'b0;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !load_done; i++) @(negedge clk);
    check("wait_done", 32'(load_done), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_fetch(input logic [31:0] pc);
    core_pc = pc;
    #1;
    check("fetch", core_instr, model[pc[6:2]]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < Depth; i++) begin
      ram[i]   = 32'd0;
      model[i] = 32'd0;
    end

    // Reset state
    @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd1);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_done_err", {30'd0, load_done, load_err}, 32'd0);
    check("rst_core_instr", core_instr, Nop);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word load
    send(8'h02);
    expect_word(0, 32'h0010_0513);
    expect_word(1, 32'h0021_00B3);
    send_word(32'h0010_0513, 1'b0);
    send_word(32'h0021_00B3, 1'b0);
    byte_valid = 1'b0;
    check("basic_cpu_rst_during_write", 32'(cpu_rst_n), 32'd0);
    @(negedge clk);
    check("basic_cpu_rst_after", 32'(cpu_rst_n), 32'd1);
    check("basic_ready_done", 32'(byte_ready), 32'd0);
    wait_done();
    check_fetch(32'h4);
    check("basic_fetch_pc4", core_instr, 32'h0021_00B3);

    // Zero count
    pulse_reload();
    check("reload_cpu_rst", 32'(cpu_rst_n), 32'd0);
    send(8'h00);
    byte_valid = 1'b0;
    check("zero_done", 32'(load_done), 32'd1);
    check("zero_cpu_rst", 32'(cpu_rst_n), 32'd1);
    check("zero_ready", 32'(byte_ready), 32'd0);
    check("zero_we", 32'(mem_we), 32'd0);

    // Overflow count is sticky until reload
    pulse_reload();
    send(8'h21);
    byte_data = 8'h55;
    check("ovf_err", 32'(load_err), 32'd1);
    check("ovf_cpu_rst", 32'(cpu_rst_n), 32'd0);
    check("ovf_instr", core_instr, Nop);
    for (int i = 0; i < 3; i++) begin
      check("ovf_ready", 32'(byte_ready), 32'd0);
      @(negedge clk);
    end
    check("ovf_still_err", 32'(load_err), 32'd1);
    pulse_reload();
    check("ovf_reload_err", 32'(load_err), 32'd0);
    check("ovf_reload_ready", 32'(byte_ready), 32'd1);

    // Back-to-back full-depth load with valid held high
    send(8'h20);
    for (int i = 0; i < Depth; i++) begin
      logic [31:0] w;
      w = $urandom;
      expect_word(i, w);
      send_word(w, 1'b0);
    end
    idle(1);
    wait_done();
    check_fetch(32'h7C);
    check_fetch(32'h80 + 32'h9);

    // Mid-load abort keeps the completed word, drops the partial one
    pulse_reload();
    send(8'h03);
    expect_word(0, 32'hCAFE_F00D);
    send_word(32'hCAFE_F00D, 1'b0);
    send(8'hAA);
    send(8'hBB);
    pulse_reload();
    check("abort_ready", 32'(byte_ready), 32'd1);
    check("abort_done", 32'(load_done), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    send(8'h01);
    expect_word(0, 32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF, 1'b0);
    idle(1);
    wait_done();
    check_fetch(32'h0);
    check_fetch(32'h4);

    // Async reset during a write cycle
    pulse_reload();
    send(8'h02);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    byte_data = 8'h44;
    check("ar_ready", 32'(byte_ready), 32'd1);
    @(posedge clk);
    #2;
    byte_valid = 1'b0;
    check("ar_we_high", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_we_low", 32'(mem_we), 32'd0);
    check("ar_cpu_rst", 32'(cpu_rst_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("ar_ready_after", 32'(byte_ready), 32'd1);
    send(8'h01);
    expect_word(0, 32'h0BAD_F00D);
    send_word(32'h0BAD_F00D, 1'b0);
    idle(1);
    wait_done();
    check_fetch(32'h0);

    // Randomized loads with idle gaps
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, Depth);
      pulse_reload();
      send(8'(n));
      for (int i = 0; i < n; i++) begin
        logic [31:0] w;
        w = $urandom;
        expect_word(i, w);
        send_word(w, 1'b1);
      end
      idle(2);
      wait_done();
      for (int k = 0; k < 4; k++) check_fetch($urandom);
    end

    idle(3);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
